// File: rtl/mag_comp_arbiter_if.sv
// Requester-side bundle for mag_comp_arbiter. Clients drive req and the
// operand buses; the arbiter answers with grant, busy and the tagged result.
interface mag_comp_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_in;
  logic [NREQ*WIDTH-1:0] b_in;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic                  res_valid;
  logic [IDW-1:0]        res_id;
  logic                  a_gt_b;
  logic                  a_lt_b;
  logic                  a_eq_b;

  // Client side: raises requests and presents operands.
  modport master (
    output req, a_in, b_in,
    input  grant, busy, res_valid, res_id, a_gt_b, a_lt_b, a_eq_b
  );

  // Arbiter side: owns grant and the result signals.
  modport slave (
    input  req, a_in, b_in,
    output grant, busy, res_valid, res_id, a_gt_b, a_lt_b, a_eq_b
  );
endinterface

// File: rtl/mag_comp_arbiter.sv
// Round-robin arbiter in front of a single registered unsigned magnitude
// comparator. One transaction takes three cycles: IDLE picks a winner and
// captures its operands, GNT pulses grant, RES pulses res_valid with flags.
module mag_comp_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) (
  input  logic               clock,
  input  logic               reset,
  mag_comp_arbiter_if.slave  bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GNT  = 2'd1;
  localparam logic [1:0] S_RES  = 2'd2;

  logic [1:0]       state_q,     state_d;
  logic [IDW-1:0]   rr_ptr_q,    rr_ptr_d;
  logic [WIDTH-1:0] a_q,         a_d;
  logic [WIDTH-1:0] b_q,         b_d;
  logic [NREQ-1:0]  grant_q,     grant_d;
  logic             busy_q,      busy_d;
  logic             res_valid_q, res_valid_d;
  logic [IDW-1:0]   res_id_q,    res_id_d;
  logic             gt_q,        gt_d;
  logic             lt_q,        lt_d;
  logic             eq_q,        eq_d;

  logic             win_found;
  logic [IDW-1:0]   win_idx;
  logic [IDW-1:0]   cand_idx;
  logic [IDW-1:0]   win_next;

  // Round-robin search: first asserted req starting at rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand_idx = IDW'((32'(rr_ptr_q) + i) % NREQ);
      if (!win_found && bus.req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
    win_next = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
  end

  // Next-state logic for the transaction FSM and all registered outputs.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    grant_d     = '0;
    res_valid_d = 1'b0;
    res_id_d    = res_id_q;
    gt_d        = gt_q;
    lt_d        = lt_q;
    eq_d        = eq_q;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d  = S_GNT;
          grant_d  = NREQ'(1) << win_idx;
          a_d      = bus.a_in[win_idx*WIDTH +: WIDTH];
          b_d      = bus.b_in[win_idx*WIDTH +: WIDTH];
          res_id_d = win_idx;
          rr_ptr_d = win_next;
        end
      end
      S_GNT: begin
        state_d     = S_RES;
        res_valid_d = 1'b1;
        gt_d        = (a_q > b_q);
        lt_d        = (a_q < b_q);
        eq_d        = (a_q == b_q);
      end
      S_RES: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // busy is registered, so it follows the state being entered.
    busy_d = (state_d == S_GNT) || (state_d == S_RES);
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      gt_q        <= 1'b0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      gt_q        <= gt_d;
      lt_q        <= lt_d;
      eq_q        <= eq_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.a_gt_b    = gt_q;
  assign bus.a_lt_b    = lt_q;
  assign bus.a_eq_b    = eq_q;
endmodule

// File: tb/tb_mag_comp_arbiter.sv
// Bench for mag_comp_arbiter: a transaction-level reference model checked on
// every falling edge, plus directed scenarios with hand-computed literals.
module tb_mag_comp_arbiter;
  localparam int WIDTH = 4;
  localparam int NREQ  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mag_comp_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  mag_comp_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: cycles since the grant (-1 = no transaction), last winner,
  // and the answer the comparator owes for the current transaction.
  int               m_since = -1;
  int               m_last  = NREQ - 1;
  int               m_gw    = 0;
  int               m_id    = 0;
  int               m_flags = 0;
  logic [WIDTH-1:0] m_a, m_b;

  initial begin
    forever begin
      @(posedge clk);
      if (rst === 1'b1) begin
        m_since = -1;
        m_last  = NREQ - 1;
        m_id    = 0;
        m_flags = 0;
      end else if (m_since == -1) begin
        for (int k = 1; k <= NREQ; k++) begin
          int w;
          w = (m_last + k) % NREQ;
          if (m_since == -1 && bus.req[w] === 1'b1) begin
            m_since = 0;
            m_last  = w;
            m_gw    = w;
            m_id    = w;
            m_a     = bus.a_in[w*WIDTH +: WIDTH];
            m_b     = bus.b_in[w*WIDTH +: WIDTH];
          end
        end
      end else if (m_since == 0) begin
        m_since = 1;
        m_flags = (m_a > m_b) ? 4 : ((m_a < m_b) ? 2 : 1);
      end else begin
        m_since = -1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      logic [NREQ-1:0] eg;
      @(negedge clk);
      eg = '0;
      if (m_since == 0) eg[m_gw] = 1'b1;
      chk("model_grant", 32'(bus.grant), 32'(eg));
      chk("model_busy", 32'(bus.busy), (m_since >= 0) ? 32'd1 : 32'd0);
      chk("model_res_valid", 32'(bus.res_valid), (m_since == 1) ? 32'd1 : 32'd0);
      chk("model_res_id", 32'(bus.res_id), 32'(m_id));
      chk("model_flags", 32'({bus.a_gt_b, bus.a_lt_b, bus.a_eq_b}), 32'(m_flags));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.a_in[idx*WIDTH +: WIDTH] = a;
    bus.b_in[idx*WIDTH +: WIDTH] = b;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.req = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  // One isolated transaction from requester idx, checked against literals.
  task automatic single(input string tag, input int idx, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [NREQ-1:0] exp_grant,
                        input int exp_id, input logic [2:0] exp_flags);
    set_ops(idx, a, b);
    bus.req = '0;
    bus.req[idx] = 1'b1;
    step();
    chk({tag, "_grant"}, 32'(bus.grant), 32'(exp_grant));
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    bus.req = '0;
    step();
    chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd1);
    chk({tag, "_res_id"}, 32'(bus.res_id), 32'(exp_id));
    chk({tag, "_flags"}, 32'({bus.a_gt_b, bus.a_lt_b, bus.a_eq_b}), 32'(exp_flags));
    step();
    chk({tag, "_done_rv"}, 32'(bus.res_valid), 32'd0);
    chk({tag, "_done_busy"}, 32'(bus.busy), 32'd0);
  endtask

  logic [NREQ-1:0] g   [5];
  int              rid [5];
  int              rcy [5];
  logic [2:0]      rfl [5];
  int              cyc, ng, nr;
  logic [NREQ-1:0] eg4 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  int              ei4 [5] = '{0, 1, 2, 3, 0};
  logic [2:0]      ef4 [5] = '{3'b010, 3'b001, 3'b100, 3'b100, 3'b010};

  initial begin
    rst      = 1'b1;
    bus.req  = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    step();
    step();
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_id", 32'(bus.res_id), 32'd0);
    chk("rst_flags", 32'({bus.a_gt_b, bus.a_lt_b, bus.a_eq_b}), 32'd0);
    rst = 1'b0;

    // Idle with no requests.
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_grant", 32'(bus.grant), 32'd0);
      chk("idle_res_valid", 32'(bus.res_valid), 32'd0);
    end

    // Single requester, the three compare outcomes, then a wrapped operand.
    single("t2_gt", 0, 4'd10, 4'd9, 4'b0001, 0, 3'b100);
    single("t2_lt", 0, 4'd2, 4'd11, 4'b0001, 0, 3'b010);
    single("t2_eq", 0, 4'd15, 4'd15, 4'b0001, 0, 3'b001);
    single("t3_wrap", 1, 4'd1, -4'd10, 4'b0010, 1, 3'b010);

    // All four requesting continuously from a fresh pointer.
    do_reset();
    set_ops(0, 4'd3, 4'd8);
    set_ops(1, 4'd7, 4'd7);
    set_ops(2, 4'd12, 4'd2);
    set_ops(3, 4'd5, 4'd1);
    for (int k = 0; k < 5; k++) begin
      g[k] = '0; rid[k] = -1; rcy[k] = 0; rfl[k] = '0;
    end
    cyc = 0; ng = 0; nr = 0;
    bus.req = '1;
    while (nr < 5 && cyc < 40) begin
      step();
      cyc++;
      if (bus.grant != '0 && ng < 5) begin
        g[ng] = bus.grant;
        ng++;
      end
      if (bus.res_valid === 1'b1 && nr < 5) begin
        rid[nr] = int'(bus.res_id);
        rcy[nr] = cyc;
        rfl[nr] = {bus.a_gt_b, bus.a_lt_b, bus.a_eq_b};
        nr++;
      end
    end
    bus.req = '0;
    for (int k = 0; k < 5; k++) begin
      chk("t4_grant", 32'(g[k]), 32'(eg4[k]));
      chk("t4_res_id", 32'(rid[k]), 32'(ei4[k]));
      chk("t4_flags", 32'(rfl[k]), 32'(ef4[k]));
    end
    for (int k = 1; k < 5; k++) chk("t4_gap", 32'(rcy[k] - rcy[k-1]), 32'd3);
    step();
    step();

    // Pointer wrap: after requester 2 wins, 0 beats 2 on req=0101.
    do_reset();
    single("t5_first", 2, 4'd9, 4'd3, 4'b0100, 2, 3'b100);
    set_ops(0, 4'd4, 4'd9);
    set_ops(2, 4'd0, 4'd0);
    g[0] = '0; g[1] = '0;
    ng = 0; cyc = 0;
    bus.req = 4'b0101;
    while (ng < 2 && cyc < 20) begin
      step();
      cyc++;
      if (bus.grant != '0) begin
        g[ng] = bus.grant;
        ng++;
      end
    end
    bus.req = '0;
    chk("t5_grant0", 32'(g[0]), 32'h1);
    chk("t5_grant1", 32'(g[1]), 32'h4);
    step();
    step();
    step();

    // Reset during GNT drops the transaction and rewinds the pointer.
    do_reset();
    single("t6_pre", 1, 4'd6, 4'd6, 4'b0010, 1, 3'b001);
    set_ops(2, 4'd1, 4'd2);
    bus.req = 4'b0100;
    step();
    chk("t6_gnt", 32'(bus.grant), 32'h4);
    rst = 1'b1;
    bus.req = '0;
    step();
    chk("t6_rst_grant", 32'(bus.grant), 32'd0);
    chk("t6_rst_busy", 32'(bus.busy), 32'd0);
    chk("t6_rst_rv", 32'(bus.res_valid), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_no_rv", 32'(bus.res_valid), 32'd0);
    end
    set_ops(1, 4'd8, 4'd3);
    set_ops(3, 4'd0, 4'd3);
    bus.req = 4'b1010;
    step();
    chk("t6_ptr0_grant", 32'(bus.grant), 32'h2);
    bus.req = '0;
    step();
    chk("t6_ptr0_id", 32'(bus.res_id), 32'd1);
    chk("t6_ptr0_flags", 32'({bus.a_gt_b, bus.a_lt_b, bus.a_eq_b}), 32'b100);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
